// File: rtl/mul_div_pkg.sv
`default_nettype none
// ============================================================================
// Module : mul_div_pkg
// Brief  : Shared types and constants for the sequential multiply/divide core.
// Rev    : 1.0
// ============================================================================
package mul_div_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_ITERS = 32;
    localparam int DIV_ITERS = 33;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/multiplicand_n_divider_register.sv
`default_nettype none
// ============================================================================
// Module : multiplicand_n_divider_register
// Brief  : 64-bit holding register for the shifted multiplicand / divisor.
// Rev    : 1.0
// ============================================================================
module multiplicand_n_divider_register (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] data_in,
    output logic [63:0] data_out
);

    logic [63:0] r_data_q;
    logic [63:0] w_data_d;

    always_comb begin
        w_data_d = data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= w_data_d;
        end
    end

    assign data_out = r_data_q;

endmodule
`default_nettype wire

// File: rtl/seq_mul_div_core.sv
`default_nettype none
// ============================================================================
// Module : seq_mul_div_core
// Brief  : Iterative unsigned 32x32 shift-add multiplier / restoring divider.
// Rev    : 1.0
// ============================================================================
module seq_mul_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo,
    output logic            div_by_zero
);
    import mul_div_pkg::*;

    state_e            r_state_q, w_state_d;
    logic [5:0]        r_cnt_q, w_cnt_d;
    logic [2*XLEN-1:0] r_prod_q, w_prod_d;
    logic [XLEN-1:0]   r_mq_q, w_mq_d;
    logic              r_dbz_pend_q, w_dbz_pend_d;
    logic [XLEN-1:0]   r_res_hi_q, w_res_hi_d;
    logic [XLEN-1:0]   r_res_lo_q, w_res_lo_d;
    logic              r_dbz_q, w_dbz_d;

    logic [2*XLEN-1:0] w_sreg_in, w_sreg_out;
    logic [2*XLEN-1:0] w_sum;
    logic [2*XLEN:0]   w_diff;

    multiplicand_n_divider_register u_sreg (
        .clk      (clk),
        .reset    (reset),
        .data_in  (w_sreg_in),
        .data_out (w_sreg_out)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_prod_d     = r_prod_q;
        w_mq_d       = r_mq_q;
        w_dbz_pend_d = r_dbz_pend_q;
        w_res_hi_d   = r_res_hi_q;
        w_res_lo_d   = r_res_lo_q;
        w_dbz_d      = r_dbz_q;
        w_sreg_in    = w_sreg_out;
        w_sum        = r_prod_q + w_sreg_out;
        // Extra borrow bit keeps large divisors from aliasing into a "fits".
        w_diff       = {1'b0, r_prod_q} - {1'b0, w_sreg_out};
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_cnt_d      = '0;
                    w_dbz_pend_d = (op == OP_DIV) && (operand_b == '0);
                    if (op == OP_MUL) begin
                        w_sreg_in = {{XLEN{1'b0}}, operand_a};
                        w_prod_d  = '0;
                        w_mq_d    = operand_b;
                        w_state_d = ST_MUL;
                    end else begin
                        w_sreg_in = {operand_b, {XLEN{1'b0}}};
                        w_prod_d  = {{XLEN{1'b0}}, operand_a};
                        w_mq_d    = '0;
                        w_state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                if (r_mq_q[0]) begin
                    w_prod_d = w_sum;
                end
                w_sreg_in = w_sreg_out << 1;
                w_mq_d    = r_mq_q >> 1;
                w_cnt_d   = r_cnt_q + 6'd1;
                if (r_cnt_q == 6'(MUL_ITERS - 1)) begin
                    w_state_d  = ST_DONE;
                    w_res_hi_d = w_prod_d[2*XLEN-1:XLEN];
                    w_res_lo_d = w_prod_d[XLEN-1:0];
                    w_dbz_d    = 1'b0;
                end
            end
            ST_DIV: begin
                busy = 1'b1;
                if (!w_diff[2*XLEN]) begin
                    w_prod_d = w_diff[2*XLEN-1:0];
                    w_mq_d   = {r_mq_q[XLEN-2:0], 1'b1};
                end else begin
                    w_mq_d   = {r_mq_q[XLEN-2:0], 1'b0};
                end
                w_sreg_in = w_sreg_out >> 1;
                w_cnt_d   = r_cnt_q + 6'd1;
                if (r_cnt_q == 6'(DIV_ITERS - 1)) begin
                    w_state_d  = ST_DONE;
                    w_res_hi_d = w_prod_d[XLEN-1:0];
                    w_res_lo_d = w_mq_d;
                    w_dbz_d    = r_dbz_pend_q;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= '0;
            r_prod_q     <= '0;
            r_mq_q       <= '0;
            r_dbz_pend_q <= 1'b0;
            r_res_hi_q   <= '0;
            r_res_lo_q   <= '0;
            r_dbz_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_prod_q     <= w_prod_d;
            r_mq_q       <= w_mq_d;
            r_dbz_pend_q <= w_dbz_pend_d;
            r_res_hi_q   <= w_res_hi_d;
            r_res_lo_q   <= w_res_lo_d;
            r_dbz_q      <= w_dbz_d;
        end
    end

    // Results are captured at completion so they stay readable during the next op.
    assign result_hi   = r_res_hi_q;
    assign result_lo   = r_res_lo_q;
    assign div_by_zero = r_dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_div_core.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_mul_div_core
// Brief  : Self-checking bench: vector table, corner sequences, random ops.
// Rev    : 1.0
// ============================================================================
module tb_seq_mul_div_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        div_by_zero;

    int n_vec = 0;
    int n_mis = 0;

    seq_mul_div_core #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference for both operations.
    function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz);
        logic [63:0] p;
        if (o == 1'b0) begin
            p   = {32'b0, a} * {32'b0, b};
            hi  = p[63:32];
            lo  = p[31:0];
            dbz = 1'b0;
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dbz = 1'b1;
        end else begin
            hi  = a % b;
            lo  = a / b;
            dbz = 1'b0;
        end
    endfunction

    // Issue one op; returns at the negedge of the done cycle (or on timeout).
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] ehi, elo;
        logic        edbz;
        logic        ro;
        logic [31:0] ra, rb;

        tbl[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0,          32'h0000_000F, 1'b0, 33};
        tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        tbl[2] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 34};
        tbl[4] = '{1'b1, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 34};
        tbl[5] = '{1'b0, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0, 33};

        reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi",   64'(result_hi), 64'd0);
        chk("reset_lo",   64'(result_lo), 64'd0);
        chk("reset_dbz",  64'(div_by_zero), 64'd0);
        reset = 1'b0;

        // Back-to-back ops: each start lands in the cycle after the previous done.
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].o, tbl[i].a, tbl[i].b, lat);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("tbl%0d_hi", i),  64'(result_hi), 64'(tbl[i].hi));
            chk($sformatf("tbl%0d_lo", i),  64'(result_lo), 64'(tbl[i].lo));
            chk($sformatf("tbl%0d_dbz", i), 64'(div_by_zero), 64'(tbl[i].dbz));
        end

        // start while busy is ignored; previous result stays readable meanwhile.
        @(negedge clk);
        start = 1'b1; op = 1'b0; operand_a = 32'd3; operand_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("busy_cycle1", 64'(busy), 64'd1);
        @(negedge clk);
        chk("hold_prev_lo", 64'(result_lo), 64'd42);
        repeat (2) @(negedge clk);
        start = 1'b1; op = 1'b1; operand_a = 32'd100; operand_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_lat", 64'(lat), 64'd33);
        chk("ignore_hi",  64'(result_hi), 64'd0);
        chk("ignore_lo",  64'(result_lo), 64'd15);
        chk("ignore_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);

        // Reset at cycle 10 of a divide.
        start = 1'b1; op = 1'b1; operand_a = 32'd100; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_lo",   64'(result_lo), 64'd0);
        chk("rst_mid_hi",   64'(result_hi), 64'd0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("rst_no_done", 64'(seen), 64'd0);
        do_op(1'b0, 32'd6, 32'd7, lat);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_lo",  64'(result_lo), 64'd42);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = 32'($urandom);
            endcase
            model(ro, ra, rb, ehi, elo, edbz);
            do_op(ro, ra, rb, lat);
            chk($sformatf("rnd%0d_lat op=%0d a=%h b=%h", i, ro, ra, rb), 64'(lat), ro ? 64'd34 : 64'd33);
            chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, ro, ra, rb),  64'(result_hi), 64'(ehi));
            chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, ro, ra, rb),  64'(result_lo), 64'(elo));
            chk($sformatf("rnd%0d_dbz op=%0d a=%h b=%h", i, ro, ra, rb), 64'(div_by_zero), 64'(edbz));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
